conv_term_gen: RTL and testbench
================================

# conv_term_gen

Producer side of the filter's product bus. Loads a MASK_WIDTH×MASK_WIDTH set of signed Q1.15 coefficients, buffers a raster pixel stream in line buffers to form the sliding window, multiplies every window pixel by its coefficient, and drives the packed product bus that the downstream adder tree sums. No backpressure: the adder tree consumes a product set every cycle it is presented.

## Interface
- PIX_BIT, 8, unsigned pixel width
- MASK_WIDTH, 7, window side (odd, ≥3)
- COFCNT_BIT, 15, coefficient fraction bits; coefficient is signed COFCNT_BIT+1 bits
- IMG_WIDTH, 640, pixels per image line
- TERM_SIZE, MASK_WIDTH**2, products per window
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- coef_start  in  1  pulse: begin (re)loading coefficients
- coef_wr  in  1  coefficient write strobe
- coef_in  in  COFCNT_BIT+1  signed coefficient, Q1.15
- coef_ready  out  1  all TERM_SIZE coefficients loaded
- sof  in  1  start of frame
- pix_valid  in  1  pixel strobe
- pix_in  in  PIX_BIT  unsigned pixel
- term_valid  out  1  term_out holds a complete product set
- term_out  out  (PIX_BIT+COFCNT_BIT+1)*TERM_SIZE  packed signed products; term t at bits [W*t+W-1 : W*t], W=PIX_BIT+COFCNT_BIT+1

## Operation
- States: LOAD, RUN. Reset → LOAD, coef count 0, all coefficients 0, col/row counters 0.
- LOAD: each coef_wr stores coef_in at index = count, count++. On the TERM_SIZE-th write → RUN, coef_ready=1. Pixels ignored in LOAD.
- RUN: coef_wr ignored. coef_start (any state) → LOAD, count 0, coef_ready=0 next edge; coef_start with coef_wr same cycle: start wins and that write is stored as index 0.
- Window: MASK_WIDTH-1 circular line buffers, IMG_WIDTH deep, addressed by col counter; plus MASK_WIDTH×MASK_WIDTH shift register. Element (r,c): r=0 oldest line, c=0 oldest column. Term index t = r*MASK_WIDTH + c, paired with coefficient t (t-th written).
- Counters advance only on accepted pixel (pix_valid in RUN). col wraps IMG_WIDTH-1 → 0 with row++; row saturates at MASK_WIDTH-1.
- Window valid when accepted pixel has row ≥ MASK_WIDTH-1 and col ≥ MASK_WIDTH-1; no border outputs (IMG_WIDTH-MASK_WIDTH+1 sets per line).
- sof: col,row ← 0; if pix_valid same cycle, that pixel is (row 0, col 0). Line-buffer contents not cleared (masked by row counter).
- Arithmetic: pixel zero-extended to PIX_BIT+1 signed, multiplied by signed coefficient, result truncated to W bits (exact: |255·−32768| < 2^23).

## Timing
- Pixel accepted at edge k → term_out/term_valid registered at edge k+2. term_valid is a one-cycle pulse per valid window; term_out holds last value otherwise.
- Gaps in pix_valid insert equal gaps in term_valid; no bubbles otherwise.
- Products already in flight at sof or coef_start still emit; windows accepted after coef_start → LOAD are not produced.
- Reset values: term_valid 0, term_out 0, coef_ready 0. Reset mid-frame drops in-flight products (term_valid 0 from edge after reset).

## Test plan
(MASK_WIDTH=3, IMG_WIDTH=8, PIX_BIT=8, COFCNT_BIT=15)
- Reset held 2 cycles → term_valid 0, term_out 0, coef_ready 0; pixels sent in LOAD produce no term_valid.
- Write coefficients 1..9 → coef_ready rises on the edge after the 9th coef_wr, not before; 10th write ignored.
- Constant pixel 10, continuous → first term_valid 2 cycles after 19th pixel (row 2, col 2); term t = 10*(t+1); 6 sets per line.
- Coefficient all 0x8000, pixel 255 → every term = 24'h808000; coefficient 0x7FFF, pixel 255 → 24'h7F7F01.
- Ramp pixel = col+8*row, coef t = 1 only at t=4 → term[4] equals centre pixel; pix_valid every other cycle → term_valid spacing 2.
- sof asserted at row 3 col 5 → next 18 accepted pixels produce no term_valid; coef_start during RUN → coef_ready drops next edge, no further term_valid until 9 writes complete.

Source files
------------

// File: rtl/conv_term_gen.sv
`default_nettype none
// ============================================================================
// Module : conv_term_gen
// Brief  : Sliding-window pixel x coefficient product generator that feeds
//          the packed product bus of the downstream adder tree.
// Rev    : 1.0  initial release
// ============================================================================
module conv_term_gen #(
    parameter int PIX_BIT    = 8,
    parameter int MASK_WIDTH = 7,
    parameter int COFCNT_BIT = 15,
    parameter int IMG_WIDTH  = 640,
    parameter int TERM_SIZE  = MASK_WIDTH * MASK_WIDTH
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          coef_start,
    input  logic                                          coef_wr,
    input  logic signed [COFCNT_BIT:0]                    coef_in,
    output logic                                          coef_ready,
    input  logic                                          sof,
    input  logic                                          pix_valid,
    input  logic [PIX_BIT-1:0]                            pix_in,
    output logic                                          term_valid,
    output logic [(PIX_BIT+COFCNT_BIT+1)*TERM_SIZE-1:0]   term_out
);

    localparam int c_W     = PIX_BIT + COFCNT_BIT + 1;
    localparam int c_CNT_W = $clog2(TERM_SIZE);
    localparam int c_COL_W = $clog2(IMG_WIDTH);
    localparam int c_ROW_W = $clog2(MASK_WIDTH);
    localparam int c_LINES = MASK_WIDTH - 1;

    localparam logic [0:0] c_ST_LOAD = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    logic [0:0]                r_state;
    logic [c_CNT_W-1:0]        r_cnt;
    logic signed [COFCNT_BIT:0] r_coef [TERM_SIZE];
    logic [c_COL_W-1:0]        r_col;
    logic [c_ROW_W-1:0]        r_row;
    logic [PIX_BIT-1:0]        r_lb   [c_LINES][IMG_WIDTH];
    logic [PIX_BIT-1:0]        r_win  [TERM_SIZE];
    logic                      r_v1;
    logic                      r_v2;
    logic [c_W*TERM_SIZE-1:0]  r_prod;

    logic                      w_accept;
    logic [c_COL_W-1:0]        w_col;
    logic [c_ROW_W-1:0]        w_row;
    logic                      w_col_last;
    logic                      w_win_ok;
    logic [PIX_BIT-1:0]        w_newcol [MASK_WIDTH];
    logic [c_W*TERM_SIZE-1:0]  w_prod;

    // A pixel arriving with sof is position (0,0) regardless of the counters.
    assign w_accept   = pix_valid && (r_state == c_ST_RUN);
    assign w_col      = sof ? '0 : r_col;
    assign w_row      = sof ? '0 : r_row;
    assign w_col_last = (w_col == c_COL_W'(IMG_WIDTH - 1));
    assign w_win_ok   = (w_row == c_ROW_W'(MASK_WIDTH - 1)) &&
                        (w_col >= c_COL_W'(MASK_WIDTH - 1));

    generate
        for (genvar r = 0; r < c_LINES; r++) begin : g_col
            assign w_newcol[r] = r_lb[r][w_col];
        end
    endgenerate
    assign w_newcol[MASK_WIDTH-1] = pix_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_LOAD;
            r_cnt      <= '0;
            coef_ready <= 1'b0;
            for (int t = 0; t < TERM_SIZE; t++) r_coef[t] <= '0;
        end else if (coef_start) begin
            r_state    <= c_ST_LOAD;
            coef_ready <= 1'b0;
            if (coef_wr) begin
                r_coef[0] <= coef_in;
                r_cnt     <= c_CNT_W'(1);
            end else begin
                r_cnt     <= '0;
            end
        end else if (r_state == c_ST_LOAD && coef_wr) begin
            r_coef[r_cnt] <= coef_in;
            if (r_cnt == c_CNT_W'(TERM_SIZE - 1)) begin
                r_state    <= c_ST_RUN;
                coef_ready <= 1'b1;
                r_cnt      <= '0;
            end else begin
                r_cnt      <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            r_col <= w_col_last ? '0 : w_col + c_COL_W'(1);
            if (w_col_last && w_row != c_ROW_W'(MASK_WIDTH - 1))
                r_row <= w_row + c_ROW_W'(1);
            else
                r_row <= w_row;
        end else if (sof) begin
            r_col <= '0;
            r_row <= '0;
        end
    end

    // Line buffer i moves up to i-1 as the column is rewritten; row 0 is oldest.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < c_LINES; i++) r_lb[i][w_col] <= w_newcol[i+1];
            for (int r = 0; r < MASK_WIDTH; r++) begin
                for (int c = 0; c < MASK_WIDTH - 1; c++)
                    r_win[r*MASK_WIDTH+c] <= r_win[r*MASK_WIDTH+c+1];
                r_win[r*MASK_WIDTH+MASK_WIDTH-1] <= w_newcol[r];
            end
        end
    end

    generate
        for (genvar t = 0; t < TERM_SIZE; t++) begin : g_term
            logic signed [c_W-1:0] w_pix_s;
            logic signed [c_W-1:0] w_coef_s;
            assign w_pix_s  = $signed({{(c_W-PIX_BIT){1'b0}}, r_win[t]});
            assign w_coef_s = {{(c_W-COFCNT_BIT-1){r_coef[t][COFCNT_BIT]}}, r_coef[t]};
            assign w_prod[c_W*t +: c_W] = w_pix_s * w_coef_s;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_prod     <= '0;
            term_valid <= 1'b0;
            term_out   <= '0;
        end else begin
            r_v1       <= w_accept && w_win_ok;
            r_v2       <= r_v1;
            term_valid <= r_v2;
            if (r_v1) r_prod   <= w_prod;
            if (r_v2) term_out <= r_prod;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_term_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_conv_term_gen
// Brief  : Scoreboard bench for conv_term_gen (3x3 window, 8-pixel lines).
// Rev    : 1.0  initial release
// ============================================================================
module tb_conv_term_gen;

    localparam int c_PB = 8;
    localparam int c_MW = 3;
    localparam int c_CB = 15;
    localparam int c_IW = 8;
    localparam int c_TS = 9;
    localparam int c_W  = 24;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     coef_start;
    logic                     coef_wr;
    logic signed [c_CB:0]     coef_in;
    logic                     coef_ready;
    logic                     sof;
    logic                     pix_valid;
    logic [c_PB-1:0]          pix_in;
    logic                     term_valid;
    logic [c_W*c_TS-1:0]      term_out;

    always #5 clk = ~clk;

    conv_term_gen #(
        .PIX_BIT(c_PB), .MASK_WIDTH(c_MW), .COFCNT_BIT(c_CB),
        .IMG_WIDTH(c_IW), .TERM_SIZE(c_TS)
    ) dut (
        .clk(clk), .reset(reset), .coef_start(coef_start), .coef_wr(coef_wr),
        .coef_in(coef_in), .coef_ready(coef_ready), .sof(sof),
        .pix_valid(pix_valid), .pix_in(pix_in), .term_valid(term_valid),
        .term_out(term_out)
    );

    typedef struct {
        int                  cyc;
        logic [c_W*c_TS-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   tv_cyc[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_tv  = 0;
    exp_t e_mon;

    // Reference model state
    logic m_ready;
    int   m_cnt, m_col, m_row;
    int   m_coef [c_TS];
    int   img [64][c_IW];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (term_valid === 1'b1) begin
            n_tv++;
            tv_cyc.push_back(cyc);
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_term_valid cyc=%0d got=1 want=0", cyc);
            end else begin
                e_mon = sb.pop_front();
                if (e_mon.data !== term_out || e_mon.cyc != cyc) begin
                    n_err++;
                    $display("FAIL term_set cyc=%0d want_cyc=%0d got=%h want=%h",
                             cyc, e_mon.cyc, term_out, e_mon.data);
                end
            end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            n_vec++;
            n_err++;
            $display("FAIL missing_term_valid cyc=%0d got=%b want=1", cyc, term_valid);
            void'(sb.pop_front());
        end
    end

    // Drives one cycle, advances the model for the coming edge, returns at the next negedge.
    task automatic step(input logic v, input logic [7:0] p, input logic s,
                        input logic cs, input logic cw, input logic signed [15:0] ci,
                        input logic rst);
        logic acc;
        int   pc, pr, px, prod;
        exp_t e;
        reset = rst; pix_valid = v; pix_in = p; sof = s;
        coef_start = cs; coef_wr = cw; coef_in = ci;
        acc = v && m_ready && !rst;
        if (rst) begin
            m_ready = 1'b0; m_cnt = 0; m_col = 0; m_row = 0;
            for (int t = 0; t < c_TS; t++) m_coef[t] = 0;
            sb.delete();
        end else begin
            pc = s ? 0 : m_col;
            pr = s ? 0 : m_row;
            if (acc) begin
                img[pr & 63][pc] = int'(p);
                if (pr >= 2 && pc >= 2) begin
                    e.cyc  = cyc + 3;
                    e.data = '0;
                    for (int r = 0; r < c_MW; r++)
                        for (int c = 0; c < c_MW; c++) begin
                            px   = img[(pr - 2 + r) & 63][pc - 2 + c];
                            prod = px * m_coef[r*c_MW + c];
                            e.data[c_W*(r*c_MW+c) +: c_W] = prod[c_W-1:0];
                        end
                    sb.push_back(e);
                end
                m_col = pc + 1;
                m_row = pr;
                if (m_col == c_IW) begin
                    m_col = 0;
                    m_row = pr + 1;
                end
            end else if (s) begin
                m_col = 0; m_row = 0;
            end
            if (cs) begin
                m_ready = 1'b0; m_cnt = 0;
                if (cw) begin m_coef[0] = int'(ci); m_cnt = 1; end
            end else if (!m_ready && cw) begin
                m_coef[m_cnt] = int'(ci);
                m_cnt++;
                if (m_cnt == c_TS) begin m_ready = 1'b1; m_cnt = 0; end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'd0, 0, 0, 0, 16'sd0, 0);
    endtask

    task automatic pix(input logic [7:0] p, input logic s);
        step(1, p, s, 0, 0, 16'sd0, 0);
    endtask

    task automatic load_const(input logic signed [15:0] v);
        for (int i = 0; i < c_TS; i++) step(0, 8'd0, 0, i == 0, 1, v, 0);
    endtask

    task automatic test_reset();
        int tv0;
        step(0, 8'd0, 0, 0, 0, 16'sd0, 1);
        step(0, 8'd0, 0, 0, 0, 16'sd0, 1);
        n_vec++;
        if (term_valid !== 1'b0) begin n_err++; $display("FAIL reset_term_valid got=%b want=0", term_valid); end
        n_vec++;
        if (term_out !== '0) begin n_err++; $display("FAIL reset_term_out got=%h want=0", term_out); end
        n_vec++;
        if (coef_ready !== 1'b0) begin n_err++; $display("FAIL reset_coef_ready got=%b want=0", coef_ready); end
        tv0 = n_tv;
        for (int i = 0; i < 24; i++) pix(8'(i + 1), i == 0);
        idle(4);
        n_vec++;
        if (n_tv != tv0) begin n_err++; $display("FAIL load_pixels_ignored got=%0d pulses want=0", n_tv - tv0); end
    endtask

    task automatic test_coef_load();
        for (int i = 1; i <= 9; i++) begin
            step(0, 8'd0, 0, i == 1, 1, 16'(i), 0);
            n_vec++;
            if (coef_ready !== (i == 9)) begin
                n_err++;
                $display("FAIL coef_ready_after_write%0d got=%b want=%b", i, coef_ready, i == 9);
            end
        end
        step(0, 8'd0, 0, 0, 1, 16'sd100, 0);
        n_vec++;
        if (coef_ready !== 1'b1) begin n_err++; $display("FAIL coef_ready_tenth got=%b want=1", coef_ready); end
    endtask

    task automatic test_constant();
        int tv0, c19, idx;
        tv0 = n_tv;
        idx = tv_cyc.size();
        c19 = 0;
        for (int i = 0; i < 24; i++) begin
            if (i == 18) c19 = cyc;
            pix(8'd10, i == 0);
        end
        idle(4);
        n_vec++;
        if (n_tv - tv0 != 6) begin n_err++; $display("FAIL const_sets_per_line got=%0d want=6", n_tv - tv0); end
        n_vec++;
        if (tv_cyc.size() <= idx || tv_cyc[idx] != c19 + 3) begin
            n_err++;
            $display("FAIL const_first_latency got=%0d want=%0d", (tv_cyc.size() > idx) ? tv_cyc[idx] : -1, c19 + 3);
        end
        for (int t = 0; t < c_TS; t++) begin
            n_vec++;
            if (term_out[c_W*t +: c_W] !== 24'(10 * (t + 1))) begin
                n_err++;
                $display("FAIL const_term%0d got=%h want=%h", t, term_out[c_W*t +: c_W], 24'(10 * (t + 1)));
            end
        end
    endtask

    task automatic test_extremes();
        load_const(16'sh8000);
        for (int i = 0; i < 24; i++) pix(8'd255, i == 0);
        idle(4);
        n_vec++;
        if (term_out[c_W*8 +: c_W] !== 24'h808000) begin
            n_err++; $display("FAIL min_coef_term got=%h want=808000", term_out[c_W*8 +: c_W]);
        end
        load_const(16'sh7FFF);
        for (int i = 0; i < 24; i++) pix(8'd255, i == 0);
        idle(4);
        n_vec++;
        if (term_out[0 +: c_W] !== 24'h7F7F01) begin
            n_err++; $display("FAIL max_coef_term got=%h want=7f7f01", term_out[0 +: c_W]);
        end
    endtask

    task automatic test_ramp();
        int idx;
        for (int i = 0; i < c_TS; i++) step(0, 8'd0, 0, i == 0, 1, (i == 4) ? 16'sd1 : 16'sd0, 0);
        idx = tv_cyc.size();
        for (int i = 0; i < 32; i++) begin
            pix(8'((i % 8) + 8 * (i / 8)), i == 0);
            idle(1);
        end
        idle(4);
        for (int k = 1; k < 6; k++) begin
            n_vec++;
            if (tv_cyc.size() <= idx + k || tv_cyc[idx+k] - tv_cyc[idx+k-1] != 2) begin
                n_err++;
                $display("FAIL ramp_spacing%0d got=%0d want=2", k,
                         (tv_cyc.size() > idx + k) ? tv_cyc[idx+k] - tv_cyc[idx+k-1] : -1);
            end
        end
        n_vec++;
        if (term_out[c_W*4 +: c_W] !== 24'd22) begin
            n_err++; $display("FAIL ramp_centre got=%h want=%h", term_out[c_W*4 +: c_W], 24'd22);
        end
        n_vec++;
        if (term_out[0 +: c_W] !== 24'd0) begin
            n_err++; $display("FAIL ramp_corner got=%h want=0", term_out[0 +: c_W]);
        end
    endtask

    task automatic test_sof_mid();
        int tv0;
        for (int i = 0; i < 29; i++) pix(8'(i), i == 0);
        idle(3);
        tv0 = n_tv;
        for (int i = 0; i < 18; i++) pix(8'(100 + i), i == 0);
        idle(3);
        n_vec++;
        if (n_tv != tv0) begin n_err++; $display("FAIL sof_mid_quiet got=%0d want=0", n_tv - tv0); end
        pix(8'd200, 0);
        idle(3);
        n_vec++;
        if (n_tv - tv0 != 1) begin n_err++; $display("FAIL sof_mid_resume got=%0d want=1", n_tv - tv0); end
    endtask

    task automatic test_coef_restart();
        int tv0;
        pix(8'd1, 0);
        step(1, 8'd2, 0, 1, 0, 16'sd0, 0);
        n_vec++;
        if (coef_ready !== 1'b0) begin n_err++; $display("FAIL restart_ready_drop got=%b want=0", coef_ready); end
        idle(3);
        tv0 = n_tv;
        for (int i = 0; i < 6; i++) pix(8'd3, 0);
        idle(3);
        n_vec++;
        if (n_tv != tv0) begin n_err++; $display("FAIL restart_load_quiet got=%0d want=0", n_tv - tv0); end
        for (int i = 0; i < c_TS; i++) step(0, 8'd0, 0, 0, 1, 16'sd2, 0);
        n_vec++;
        if (coef_ready !== 1'b1) begin n_err++; $display("FAIL restart_ready_rise got=%b want=1", coef_ready); end
        tv0 = n_tv;
        for (int i = 0; i < 24; i++) pix(8'd7, i == 0);
        idle(4);
        n_vec++;
        if (n_tv - tv0 != 6) begin n_err++; $display("FAIL restart_sets got=%0d want=6", n_tv - tv0); end
        n_vec++;
        if (term_out[c_W*8 +: c_W] !== 24'd14) begin
            n_err++; $display("FAIL restart_term got=%h want=%h", term_out[c_W*8 +: c_W], 24'd14);
        end
    endtask

    initial begin
        reset = 1'b1; coef_start = 1'b0; coef_wr = 1'b0; coef_in = '0;
        sof = 1'b0; pix_valid = 1'b0; pix_in = '0;
        m_ready = 1'b0; m_cnt = 0; m_col = 0; m_row = 0;
        for (int t = 0; t < c_TS; t++) m_coef[t] = 0;
        for (int r = 0; r < 64; r++) for (int c = 0; c < c_IW; c++) img[r][c] = 0;
        @(negedge clk);
        test_reset();
        test_coef_load();
        test_constant();
        test_extremes();
        test_ramp();
        test_sof_mid();
        test_coef_restart();
        idle(5);
        n_vec++;
        if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_drain got=%0d pending want=0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
